// File: rtl/bilin_pkg.sv
// Shared types and constants for the bilinear downscaling engine.
//   state_t     : engine FSM states
//   bilin_cfg_t : run geometry latched on an accepted start
//   axis_t      : clamped neighbour coordinates plus fraction for one axis
package bilin_pkg;

    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned COORD_W   = 16;
    localparam int unsigned ONE_Q     = 256;

    typedef logic [COORD_W-1:0] q8_8_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A0,
        ST_A1,
        ST_A2,
        ST_A3,
        ST_CAP,
        ST_MUL,
        ST_WR,
        ST_HOLD,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] src_w;
        logic [PIX_W-1:0] src_h;
        logic [PIX_W-1:0] dst_w;
        logic [PIX_W-1:0] dst_h;
        q8_8_t            step_x;
        q8_8_t            step_y;
    } bilin_cfg_t;

    typedef struct packed {
        logic [PIX_W-1:0] c0;
        logic [PIX_W-1:0] c1;
        logic [PIX_W-1:0] frac;
    } axis_t;

    // Splits a Q8.8 coordinate and clamps both neighbours to size-1.
    // When the far neighbour would be clamped both taps land on the
    // same pixel, so the fraction is dropped to keep the result exact.
    function automatic axis_t clamp_axis(input q8_8_t s, input logic [PIX_W-1:0] size);
        axis_t            r;
        logic [PIX_W-1:0] lim;
        logic [PIX_W-1:0] i0;
        lim    = size - 8'd1;
        i0     = s[FRAC_BITS +: PIX_W];
        r.frac = s[FRAC_BITS-1:0];
        if (i0 >= lim) begin
            r.c0   = lim;
            r.c1   = lim;
            r.frac = '0;
        end else begin
            r.c0 = i0;
            r.c1 = i0 + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bilinear_engine_if.sv
// Control/config and SRAM bus of the bilinear engine.
//   master : control_unit / SRAM side (drives config, start, read data)
//   slave  : engine side (drives SRAM address/write and status)
interface bilinear_engine_if #(
    parameter int unsigned ADDR_BITS = 8
);

    logic                 start;
    logic                 step_mode;
    logic                 step_pulse;
    logic [7:0]           src_w;
    logic [7:0]           src_h;
    logic [7:0]           dst_w;
    logic [7:0]           dst_h;
    logic [15:0]          step_x;
    logic [15:0]          step_y;
    logic [ADDR_BITS-1:0] src_base;
    logic [ADDR_BITS-1:0] dst_base;
    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_wdata;
    logic [7:0]           mem_rdata;
    logic                 busy;
    logic                 done;
    logic [15:0]          pix_count;

    modport master (
        output start, step_mode, step_pulse, src_w, src_h, dst_w, dst_h,
               step_x, step_y, src_base, dst_base, mem_rdata,
        input  mem_we, mem_addr, mem_wdata, busy, done, pix_count
    );

    modport slave (
        input  start, step_mode, step_pulse, src_w, src_h, dst_w, dst_h,
               step_x, step_y, src_base, dst_base, mem_rdata,
        output mem_we, mem_addr, mem_wdata, busy, done, pix_count
    );

endinterface

// File: rtl/bilin_lerp.sv
// Combinational bilinear weighted sum with round-to-nearest.
//   i_p00..i_p11 : four neighbour pixels (x then y order)
//   i_fx, i_fy   : Q0.8 fractions
//   o_out_c      : interpolated pixel
module bilin_lerp
    import bilin_pkg::*;
(
    input  logic [7:0] i_p00,
    input  logic [7:0] i_p10,
    input  logic [7:0] i_p01,
    input  logic [7:0] i_p11,
    input  logic [7:0] i_fx,
    input  logic [7:0] i_fy,
    output logic [7:0] o_out_c
);

    localparam int unsigned ROUND = 1 << (2 * FRAC_BITS - 1);

    logic [15:0] w_fx_inv;
    logic [15:0] w_top;
    logic [15:0] w_bot;
    logic [23:0] w_fy_inv;
    logic [23:0] w_sum;

    // Horizontal pass: both rows stay below 255*256, so 16 bits suffice.
    assign w_fx_inv = 16'(ONE_Q) - 16'(i_fx);
    assign w_top    = 16'(i_p00) * w_fx_inv + 16'(i_p10) * 16'(i_fx);
    assign w_bot    = 16'(i_p01) * w_fx_inv + 16'(i_p11) * 16'(i_fx);

    // Vertical pass plus half-LSB rounding; the peak still fits 24 bits.
    assign w_fy_inv = 24'(ONE_Q) - 24'(i_fy);
    assign w_sum    = 24'(w_top) * w_fy_inv + 24'(w_bot) * 24'(i_fy) + 24'(ROUND);
    assign o_out_c  = 8'(w_sum >> (2 * FRAC_BITS));

endmodule

// File: rtl/bilinear_engine.sv
// Bilinear downscaler: walks the destination grid, fetches four source
// neighbours per pixel from an SRAM with one-cycle read latency, and
// writes one interpolated byte per output pixel.
//   clk    : system clock
//   aclr_n : asynchronous active-low reset
//   bus    : config/start/step inputs, SRAM port, busy/done/pix_count
module bilinear_engine
    import bilin_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic             clk,
    input  logic             aclr_n,
    bilinear_engine_if.slave bus
);

    state_t               r_state;
    state_t               w_next;
    bilin_cfg_t           r_cfg;
    logic [ADDR_BITS-1:0] r_src_base;
    logic [ADDR_BITS-1:0] r_dst_base;
    q8_8_t                r_sx;
    q8_8_t                r_sy;
    logic [7:0]           r_ox;
    logic [7:0]           r_oy;
    logic [7:0]           r_p00;
    logic [7:0]           r_p10;
    logic [7:0]           r_p01;
    logic [7:0]           r_p11;
    logic                 r_last;
    logic                 r_mem_we;
    logic [ADDR_BITS-1:0] r_mem_addr;
    logic [7:0]           r_mem_wdata;
    logic                 r_busy;
    logic                 r_done;
    logic [15:0]          r_pix_count;

    axis_t                w_ax;
    axis_t                w_ay;
    logic [7:0]           w_lerp;
    logic                 w_accept;
    logic                 w_we_d;
    logic [ADDR_BITS-1:0] w_addr_d;
    logic                 w_x_wrap;
    logic                 w_y_last;

    function automatic logic [ADDR_BITS-1:0] rd_addr(
        input logic [ADDR_BITS-1:0] base,
        input logic [7:0]           w,
        input logic [7:0]           x,
        input logic [7:0]           y
    );
        logic [15:0] off;
        off = 16'(y) * 16'(w) + 16'(x);
        return base + ADDR_BITS'(off);
    endfunction

    assign w_ax     = clamp_axis(r_sx, r_cfg.src_w);
    assign w_ay     = clamp_axis(r_sy, r_cfg.src_h);
    assign w_x_wrap = (r_ox == r_cfg.dst_w - 8'd1);
    assign w_y_last = (r_oy == r_cfg.dst_h - 8'd1);

    bilin_lerp u_lerp (
        .i_p00   (r_p00),
        .i_p10   (r_p10),
        .i_p01   (r_p01),
        .i_p11   (r_p11),
        .i_fx    (w_ax.frac),
        .i_fy    (w_ay.frac),
        .o_out_c (w_lerp)
    );

    // State register.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state plus next SRAM address/write strobe. Coordinates advance
    // at the end of MUL, so WR/HOLD already see the next pixel's taps.
    always_comb begin
        w_next   = r_state;
        w_addr_d = r_mem_addr;
        w_we_d   = 1'b0;
        w_accept = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (bus.dst_w == 8'd0 || bus.dst_h == 8'd0) begin
                        w_next = ST_DONE;
                    end else begin
                        // First pixel is always (0,0): its address is the base.
                        w_next   = ST_A0;
                        w_addr_d = bus.src_base;
                    end
                end
            end
            ST_A0: begin
                w_next   = ST_A1;
                w_addr_d = rd_addr(r_src_base, r_cfg.src_w, w_ax.c1, w_ay.c0);
            end
            ST_A1: begin
                w_next   = ST_A2;
                w_addr_d = rd_addr(r_src_base, r_cfg.src_w, w_ax.c0, w_ay.c1);
            end
            ST_A2: begin
                w_next   = ST_A3;
                w_addr_d = rd_addr(r_src_base, r_cfg.src_w, w_ax.c1, w_ay.c1);
            end
            ST_A3:  w_next = ST_CAP;
            ST_CAP: w_next = ST_MUL;
            ST_MUL: begin
                w_next   = ST_WR;
                w_we_d   = 1'b1;
                w_addr_d = r_dst_base + ADDR_BITS'(r_pix_count);
            end
            ST_WR: begin
                if (r_last) begin
                    w_next = ST_DONE;
                end else if (bus.step_mode) begin
                    w_next = ST_HOLD;
                end else begin
                    w_next   = ST_A0;
                    w_addr_d = rd_addr(r_src_base, r_cfg.src_w, w_ax.c0, w_ay.c0);
                end
            end
            ST_HOLD: begin
                if (bus.step_pulse) begin
                    w_next   = ST_A0;
                    w_addr_d = rd_addr(r_src_base, r_cfg.src_w, w_ax.c0, w_ay.c0);
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Registered status and SRAM strobes.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_mem_we   <= w_we_d;
            r_mem_addr <= w_addr_d;
            r_busy     <= (w_next != ST_IDLE);
            if (w_next == ST_DONE) begin
                r_done <= 1'b1;
            end else if (w_accept) begin
                r_done <= 1'b0;
            end
        end
    end

    // Run configuration, grid walk, result byte and pixel counter.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_cfg       <= '0;
            r_src_base  <= '0;
            r_dst_base  <= '0;
            r_sx        <= '0;
            r_sy        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_last      <= 1'b0;
            r_mem_wdata <= '0;
            r_pix_count <= '0;
        end else if (w_accept) begin
            r_cfg       <= '{src_w: bus.src_w, src_h: bus.src_h,
                             dst_w: bus.dst_w, dst_h: bus.dst_h,
                             step_x: bus.step_x, step_y: bus.step_y};
            r_src_base  <= bus.src_base;
            r_dst_base  <= bus.dst_base;
            r_sx        <= '0;
            r_sy        <= '0;
            r_ox        <= '0;
            r_oy        <= '0;
            r_last      <= 1'b0;
            r_pix_count <= '0;
        end else if (r_state == ST_MUL) begin
            r_mem_wdata <= w_lerp;
            r_last      <= w_x_wrap && w_y_last;
            if (w_x_wrap) begin
                r_ox <= '0;
                r_sx <= '0;
                r_oy <= r_oy + 8'd1;
                r_sy <= r_sy + r_cfg.step_y;
            end else begin
                r_ox <= r_ox + 8'd1;
                r_sx <= r_sx + r_cfg.step_x;
            end
        end else if (r_state == ST_WR) begin
            r_pix_count <= r_pix_count + 16'd1;
        end
    end

    // Read data arrives one cycle after its address: capture P00..P11.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_p00 <= '0;
            r_p10 <= '0;
            r_p01 <= '0;
            r_p11 <= '0;
        end else begin
            if (r_state == ST_A1)  r_p00 <= bus.mem_rdata;
            if (r_state == ST_A2)  r_p10 <= bus.mem_rdata;
            if (r_state == ST_A3)  r_p01 <= bus.mem_rdata;
            if (r_state == ST_CAP) r_p11 <= bus.mem_rdata;
        end
    end

    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pix_count = r_pix_count;

endmodule

// File: tb/tb_bilinear_engine.sv
// Directed bench for bilinear_engine with a behavioural one-cycle SRAM.
module tb_bilinear_engine;

    localparam int unsigned ADDR_BITS = 8;

    logic clk = 1'b0;
    logic aclr_n;

    always #5 clk = ~clk;

    bilinear_engine_if #(.ADDR_BITS(ADDR_BITS)) bus ();

    bilinear_engine #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .bus    (bus)
    );

    logic [7:0] mem [256];
    logic [7:0] wr_addr_log [$];
    logic [7:0] wr_data_log [$];
    logic [7:0] exp_q [$];
    logic [7:0] rd_lo, rd_hi, wr_lo, wr_hi;
    int n_tests = 0;
    int n_fail  = 0;
    int busy_cycles;
    int bad_rd;
    int k;

    // SRAM: synchronous write, read data valid one cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input logic [7:0] a);
        return (a >= rd_lo && a <= rd_hi) || (a >= wr_lo && a <= wr_hi);
    endfunction

    // One clock, then sample and log the bus away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.busy) busy_cycles++;
        if (bus.mem_we) begin
            wr_addr_log.push_back(bus.mem_addr);
            wr_data_log.push_back(bus.mem_wdata);
        end
        if (bus.busy && !bus.mem_we && !in_win(bus.mem_addr)) bad_rd++;
    endtask

    task automatic start_run(input logic [7:0] sw, input logic [7:0] sh,
                             input logic [7:0] dw, input logic [7:0] dh,
                             input logic [15:0] stp, input logic [7:0] sb,
                             input logic [7:0] db, input logic sm);
        bus.src_w     = sw;
        bus.src_h     = sh;
        bus.dst_w     = dw;
        bus.dst_h     = dh;
        bus.step_x    = stp;
        bus.step_y    = stp;
        bus.src_base  = sb;
        bus.dst_base  = db;
        bus.step_mode = sm;
        rd_lo = sb;
        rd_hi = sb + 8'(sw * sh) - 8'd1;
        wr_lo = db;
        wr_hi = db + 8'(dw * dh) - 8'd1;
        busy_cycles = 0;
        bad_rd      = 0;
        wr_addr_log.delete();
        wr_data_log.delete();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        while (bus.busy && n < limit) begin
            tick();
            n++;
        end
        check($sformatf("%s_timeout", tag), 32'(bus.busy), 32'd0);
    endtask

    task automatic check_run(input string tag, input logic [7:0] db);
        check($sformatf("%s_nwr", tag), wr_data_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_data_log.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_log[i]), 32'(db + 8'(i)));
            check($sformatf("%s_data%0d", tag, i), 32'(wr_data_log[i]), 32'(exp_q[i]));
        end
        check($sformatf("%s_pix", tag), 32'(bus.pix_count), exp_q.size());
        check($sformatf("%s_done", tag), 32'(bus.done), 32'd1);
        check($sformatf("%s_rdwin", tag), bad_rd, 0);
    endtask

    initial begin
        aclr_n         = 1'b0;
        bus.start      = 1'b0;
        bus.step_mode  = 1'b0;
        bus.step_pulse = 1'b0;
        bus.src_w      = '0;
        bus.src_h      = '0;
        bus.dst_w      = '0;
        bus.dst_h      = '0;
        bus.step_x     = '0;
        bus.step_y     = '0;
        bus.src_base   = '0;
        bus.dst_base   = '0;
        rd_lo = '0; rd_hi = '0; wr_lo = '0; wr_hi = '0;
        busy_cycles = 0;
        bad_rd      = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        mem[0]  = 8'd10;
        mem[1]  = 8'd20;
        mem[2]  = 8'd30;
        mem[3]  = 8'd40;
        mem[16] = 8'd100;
        mem[17] = 8'd200;

        repeat (3) tick();
        check("rst_busy",  32'(bus.busy),      32'd0);
        check("rst_done",  32'(bus.done),      32'd0);
        check("rst_we",    32'(bus.mem_we),    32'd0);
        check("rst_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_pix",   32'(bus.pix_count), 32'd0);
        aclr_n = 1'b1;
        tick();

        // Identity copy of the 2x2 source.
        exp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        start_run(8'd2, 8'd2, 8'd2, 8'd2, 16'h0100, 8'h00, 8'h40, 1'b0);
        wait_idle("id", 100);
        check_run("id", 8'h40);
        check("id_busy", busy_cycles, 29);

        // Half step: fractional taps; done clears after the accepted start.
        exp_q = '{8'd10, 8'd15, 8'd20, 8'd25};
        start_run(8'd2, 8'd2, 8'd2, 8'd2, 16'h0080, 8'h00, 8'h50, 1'b0);
        check("half_done_clr", 32'(bus.done), 32'd0);
        wait_idle("half", 100);
        check_run("half", 8'h50);

        // Clamp at the right edge of a 2x1 source.
        exp_q = '{8'd100, 8'd200, 8'd200};
        start_run(8'd2, 8'd1, 8'd3, 8'd1, 16'h0100, 8'h10, 8'h60, 1'b0);
        wait_idle("clamp", 100);
        check_run("clamp", 8'h60);
        check("clamp_busy", busy_cycles, 22);

        // Step mode: one pixel, long hold, then one pixel per step_pulse.
        exp_q = '{8'd10, 8'd20};
        start_run(8'd2, 8'd2, 8'd2, 8'd1, 16'h0100, 8'h00, 8'h70, 1'b1);
        k = 0;
        while (wr_data_log.size() < 1 && k < 20) begin
            tick();
            k++;
        end
        check("step_first_wr", wr_data_log.size(), 1);
        repeat (50) tick();
        check("step_hold_nowr", wr_data_log.size(), 1);
        check("step_hold_busy", 32'(bus.busy), 32'd1);
        check("step_hold_done", 32'(bus.done), 32'd0);
        bus.step_pulse = 1'b1;
        tick();
        bus.step_pulse = 1'b0;
        k = 1;
        while (!bus.mem_we && k < 20) begin
            tick();
            k++;
        end
        check("step_latency", k, 7);
        wait_idle("step", 20);
        check_run("step", 8'h70);

        // Start while busy and start in the DONE cycle are both ignored.
        exp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        start_run(8'd2, 8'd2, 8'd2, 8'd2, 16'h0100, 8'h00, 8'h80, 1'b0);
        repeat (4) tick();
        bus.start    = 1'b1;
        bus.dst_w    = 8'd1;
        bus.dst_base = 8'h90;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (!(bus.busy && bus.done) && k < 60) begin
            tick();
            k++;
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("done_start_ignored", 32'(bus.busy), 32'd0);
        check_run("restart", 8'h80);
        check("restart_busy", busy_cycles, 29);

        // Reset asserted during A2 aborts the run immediately.
        start_run(8'd2, 8'd2, 8'd2, 8'd2, 16'h0100, 8'h00, 8'hA0, 1'b0);
        repeat (2) tick();
        aclr_n = 1'b0;
        tick();
        check("mid_rst_busy",  32'(bus.busy),      32'd0);
        check("mid_rst_done",  32'(bus.done),      32'd0);
        check("mid_rst_we",    32'(bus.mem_we),    32'd0);
        check("mid_rst_addr",  32'(bus.mem_addr),  32'd0);
        check("mid_rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("mid_rst_pix",   32'(bus.pix_count), 32'd0);
        tick();
        aclr_n = 1'b1;
        tick();
        check("mid_rst_nowr", wr_data_log.size(), 0);

        // Zero-size destination: straight to DONE, no SRAM traffic.
        start_run(8'd2, 8'd2, 8'd0, 8'd2, 16'h0100, 8'h00, 8'hC0, 1'b0);
        tick();
        check("zero_done",     32'(bus.done), 32'd1);
        check("zero_busy",     32'(bus.busy), 32'd0);
        check("zero_nwr",      wr_data_log.size(), 0);
        check("zero_busy_cyc", busy_cycles, 1);

        // A full run after the aborted one completes normally.
        exp_q = '{8'd10, 8'd20, 8'd30, 8'd40};
        start_run(8'd2, 8'd2, 8'd2, 8'd2, 16'h0100, 8'h00, 8'hB0, 1'b0);
        wait_idle("post_rst", 100);
        check_run("post_rst", 8'hB0);
        check("post_rst_busy", busy_cycles, 29);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
